pq_sorted_array: RTL and testbench
==================================

# pq_sorted_array

Parametrised shift-register priority queue, the successor of the fixed 3-deep, 16-bit array priority queue. Stores up to `DEPTH` entries of {key, id}, kept sorted by key: min-first or max-first, selectable at elaboration. Ties are resolved FIFO (stable). Push and pop are allowed in the same cycle. The head entry is always presented on registered outputs. It sits between a producer issuing keyed requests (e.g. interrupt/task IDs with priorities) and a single consumer that always takes the best entry.

## Interface
- `DEPTH`, 4, number of entries; ≥2
- `DATA_WIDTH`, 16, key width
- `ID_WIDTH`, 4, tag width
- `MODE`, `PQ_MIN`, `PQ_MIN`: smallest key at head; `PQ_MAX`: largest key at head
- `clk_i` in 1, clock
- `rst_i` in 1, reset, synchronous, active-high
- `flush_i` in 1, synchronously empty the queue
- `push_valid_i` in 1, push request
- `push_ready_o` out 1, push accepted when `push_valid_i & push_ready_o`
- `push_data_i` in `DATA_WIDTH`, key
- `push_id_i` in `ID_WIDTH`, tag
- `pop_i` in 1, remove head this cycle; ignored when `head_valid_o`=0
- `head_valid_o` out 1, queue non-empty
- `head_data_o` out `DATA_WIDTH`, head key
- `head_id_o` out `ID_WIDTH`, head tag
- `count_o` out `$clog2(DEPTH+1)`, occupancy
- `full_o` out 1, `count_o == DEPTH`
- `empty_o` out 1, `count_o == 0`

## Operation
- **Storage.** `DEPTH` cells, each {valid, key, id}; cell 0 is the head. Valid cells are contiguous from 0 and sorted by key.
- **Ordering.**
  - `PQ_MIN`: a new entry is inserted before the first cell whose key is strictly greater, or before the first invalid cell.
  - `PQ_MAX`: the same, using strictly less.
  - Equal keys therefore keep arrival order.
- **Push only.** Cells at and after the insert position shift one toward the tail; the new entry loads at the insert position.
- **Pop only.** All cells shift one toward the head; the last cell becomes invalid.
- **Push and pop together.** The result equals inserting the new entry into (old queue minus old head). Count is unchanged. A new entry that beats every remaining entry becomes the head.
- **push_ready_o** = `!flush_i & (!full_o | (pop_i & head_valid_o))`.
  - This is a combinational path from `pop_i`/`flush_i`.
  - Push while full with no pop is not accepted; the producer must hold.
- **Pop on empty:** no effect.
- **Priority order:** `rst_i` > `flush_i` > push/pop.
  - `flush_i` invalidates all cells; a concurrent push or pop is discarded.
- **Reset mid-operation** discards all contents; no partial state survives.
- **Key comparison** is unsigned over the full `DATA_WIDTH`; ids are never compared.

## Timing
- All state is updated on the `clk_i` rising edge.
- `head_*_o`, `count_o`, `full_o` and `empty_o` are registered, or derived only from registers.
- **Latency.** An entry pushed in cycle N is visible at the head in N+1 if it beats the current head, or if the queue was empty.
- **Pop.** The pop in cycle N takes the head shown in N. The next head appears in N+1.
- **Back-to-back.** Push every cycle and pop every cycle are sustained; there are no bubbles.
- **Reset values (cycle after `rst_i` high):**
  - `head_valid_o`=0, `head_data_o`=0, `head_id_o`=0
  - `count_o`=0, `full_o`=0, `empty_o`=1
  - all cells zero/invalid
- **Flush.** Takes effect in 1 cycle. Outputs then match reset values.

## Structure
- **Shared package `pq_pkg` holds:**
  - enum `pq_mode_e` {`PQ_MIN`, `PQ_MAX`}
  - default constants for `DEPTH`, `DATA_WIDTH`, `ID_WIDTH`
  - the testbench cell struct with `int` data/id fields, used for the scoreboard model
- **Module-local.** The RTL cell struct is declared inside the module from its parameters, because the widths are parametrised.
- **Sub-module `pq_sorted_cell`**, one per entry.
  - Inputs: own entry, neighbour entries (head-side and tail-side), new entry, and its own and head-side neighbour's "new beats this cell" flags.
  - Function: selects hold / shift-from-head-side / shift-from-tail-side / load-new.
- **Top level:** instantiates a `DEPTH`-long chain plus count logic.

## Test plan
Defaults unless stated: `DEPTH`=4, `DATA_WIDTH`=16, `ID_WIDTH`=4, `MODE`=`PQ_MIN`.
1. **Reset.** Hold `rst_i` 2 cycles with random push/pop → `empty_o`=1, `count_o`=0, `head_valid_o`=0, `head_data_o`=0.
2. **Sorting.** Push keys 30/id1, 10/id2, 20/id3 on consecutive cycles → `head_data_o`=10 / `head_id_o`=2 one cycle after the second push. Three pops return (10,2), (20,3), (30,1); then `empty_o`=1.
3. **Stable ties.** Push 5/id1, 5/id2, 7/id3, 5/id4 → pops return ids 1, 2, 4, 3.
4. **Full boundary.** Fill with 2, 3, 4, 5 → `full_o`=1 and `push_ready_o`=0. Then push 1/id9 with `pop_i` in the same cycle → popped head is 2, new head is 1/id9, `count_o` stays 4.
5. **Flush and empty pop.**
   - Queue holds 3 entries; assert `flush_i` together with `push_valid_i` (key 8) → `push_ready_o`=0, next cycle `count_o`=0, key 8 is absent.
   - `pop_i` on the empty queue → `count_o` stays 0.
6. **Max mode.** `MODE`=`PQ_MAX`, `DEPTH`=8, `DATA_WIDTH`=32. Push 7, 9, 8, 0xFFFF_FFFF → pops return 0xFFFF_FFFF, 9, 8, 7. A random push/pop stress of 10k cycles matches the scoreboard.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and defaults for the sorted-array priority queue.
package pq_pkg;

    typedef enum logic {
        PQ_MIN = 1'b0,
        PQ_MAX = 1'b1
    } pq_mode_e;

    localparam int PQ_DEPTH      = 4;
    localparam int PQ_DATA_WIDTH = 16;
    localparam int PQ_ID_WIDTH   = 4;

    typedef struct {
        int data;
        int id;
    } pq_tb_cell_t;

endpackage

// File: rtl/pq_sorted_cell.sv
// One storage cell of the shift-register priority queue.
module pq_sorted_cell #(
    parameter int W = 21
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         beat_i,
    input  logic         beat_prev_i,
    input  logic [W-1:0] prev_i,
    input  logic [W-1:0] next_i,
    input  logic [W-1:0] new_i,
    output logic [W-1:0] cell_o
);

    // With a concurrent pop the whole array is viewed one slot toward the
    // head, so "shift from head side" collapses to holding this cell.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cell_o <= '0;
        end else if (push_i && beat_prev_i) begin
            cell_o <= pop_i ? cell_o : prev_i;
        end else if (push_i && beat_i) begin
            cell_o <= new_i;
        end else if (pop_i) begin
            cell_o <= next_i;
        end
    end

endmodule

// File: rtl/pq_sorted_array.sv
// Parametrised sorted shift-register priority queue with stable ties.
module pq_sorted_array
    import pq_pkg::*;
#(
    parameter int       DEPTH      = PQ_DEPTH,
    parameter int       DATA_WIDTH = PQ_DATA_WIDTH,
    parameter int       ID_WIDTH   = PQ_ID_WIDTH,
    parameter pq_mode_e MODE       = PQ_MIN
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [DATA_WIDTH-1:0]        push_data_i,
    input  logic [ID_WIDTH-1:0]          push_id_i,
    input  logic                         pop_i,
    output logic                         head_valid_o,
    output logic [DATA_WIDTH-1:0]        head_data_o,
    output logic [ID_WIDTH-1:0]          head_id_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = 1 + DATA_WIDTH + ID_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] key;
        logic [ID_WIDTH-1:0]   id;
    } cell_t;

    logic [W-1:0]  raw [DEPTH];
    logic [DEPTH:0] beats;
    cell_t         new_c;
    cell_t         head_c;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign new_c  = '{valid: 1'b1, key: push_data_i, id: push_id_i};
    assign head_c = cell_t'(raw[0]);

    assign push_ready_o = !flush_i && (!full_o || (pop_i && head_valid_o));
    assign do_push      = push_valid_i && push_ready_o;
    assign do_pop       = pop_i && head_valid_o && !flush_i;

    assign beats[DEPTH] = 1'b1;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [DATA_WIDTH-1:0] key;
        logic                  vld;
        logic [W-1:0]          prev;
        logic [W-1:0]          next;
        logic                  beat_prev;

        assign vld = raw[i][W-1];
        assign key = raw[i][W-2 -: DATA_WIDTH];

        if (MODE == PQ_MAX) begin : g_max
            assign beats[i] = !vld || (push_data_i > key);
        end else begin : g_min
            assign beats[i] = !vld || (push_data_i < key);
        end

        if (i == 0) begin : g_head
            assign prev      = '0;
            assign beat_prev = 1'b0;
        end else begin : g_body
            assign prev      = raw[i-1];
            assign beat_prev = do_pop ? beats[i] : beats[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign next = '0;
        end else begin : g_mid
            assign next = raw[i+1];
        end

        pq_sorted_cell #(.W(W)) u_cell (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .push_i      (do_push),
            .pop_i       (do_pop),
            .beat_i      (do_pop ? beats[i+1] : beats[i]),
            .beat_prev_i (beat_prev),
            .prev_i      (prev),
            .next_i      (next),
            .new_i       (new_c),
            .cell_o      (raw[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count_q <= '0;
        end else if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count_o      = count_q;
    assign full_o       = (count_q == CW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign head_valid_o = head_c.valid;
    assign head_data_o  = head_c.key;
    assign head_id_o    = head_c.id;

endmodule

// File: tb/tb_pq_sorted_array.sv
// Directed vectors plus scoreboard stress for pq_sorted_array.
module tb_pq_sorted_array;
    import pq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_flush, a_pv, a_pop, a_pr, a_hv, a_full, a_empty;
    logic [15:0] a_pd, a_hd;
    logic [3:0]  a_pid, a_hid;
    logic [2:0]  a_cnt;

    logic        b_flush, b_pv, b_pop, b_pr, b_hv, b_full, b_empty;
    logic [31:0] b_pd, b_hd;
    logic [3:0]  b_pid, b_hid;
    logic [3:0]  b_cnt;

    pq_sorted_array u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .push_valid_i(a_pv), .push_ready_o(a_pr),
        .push_data_i(a_pd), .push_id_i(a_pid), .pop_i(a_pop),
        .head_valid_o(a_hv), .head_data_o(a_hd), .head_id_o(a_hid),
        .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty)
    );

    pq_sorted_array #(
        .DEPTH(8), .DATA_WIDTH(32), .ID_WIDTH(4), .MODE(PQ_MAX)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .push_valid_i(b_pv), .push_ready_o(b_pr),
        .push_data_i(b_pd), .push_id_i(b_pid), .pop_i(b_pop),
        .head_valid_o(b_hv), .head_data_o(b_hd), .head_id_o(b_hid),
        .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty)
    );

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        push;
        logic [15:0] key;
        logic [3:0]  id;
        logic        pop;
        logic        hv;
        logic [15:0] hd;
        logic [3:0]  hid;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [18];
    pq_tb_cell_t q[$];

    initial begin
        logic [15:0] exp_a [3];
        logic [31:0] exp_b [4];
        logic [31:0] e_hd;
        logic [3:0]  e_hid;
        logic        e_pr, fl, pv, pp;
        logic [31:0] nk;
        logic [3:0]  nid;
        int          pos;
        pq_tb_cell_t nc;

        tbl = '{
            '{1'b1, 16'd30, 4'd1, 1'b0, 1'b1, 16'd30, 4'd1, 3'd1},
            '{1'b1, 16'd10, 4'd2, 1'b0, 1'b1, 16'd10, 4'd2, 3'd2},
            '{1'b1, 16'd20, 4'd3, 1'b0, 1'b1, 16'd10, 4'd2, 3'd3},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b1, 16'd20, 4'd3, 3'd2},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b1, 16'd30, 4'd1, 3'd1},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b0, 16'd0,  4'd0, 3'd0},
            '{1'b1, 16'd5,  4'd1, 1'b0, 1'b1, 16'd5,  4'd1, 3'd1},
            '{1'b1, 16'd5,  4'd2, 1'b0, 1'b1, 16'd5,  4'd1, 3'd2},
            '{1'b1, 16'd7,  4'd3, 1'b0, 1'b1, 16'd5,  4'd1, 3'd3},
            '{1'b1, 16'd5,  4'd4, 1'b0, 1'b1, 16'd5,  4'd1, 3'd4},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b1, 16'd5,  4'd2, 3'd3},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b1, 16'd5,  4'd4, 3'd2},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b1, 16'd7,  4'd3, 3'd1},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b0, 16'd0,  4'd0, 3'd0},
            '{1'b1, 16'd9,  4'd5, 1'b0, 1'b1, 16'd9,  4'd5, 3'd1},
            '{1'b1, 16'd4,  4'd6, 1'b1, 1'b1, 16'd4,  4'd6, 3'd1},
            '{1'b1, 16'd8,  4'd7, 1'b1, 1'b1, 16'd8,  4'd7, 3'd1},
            '{1'b0, 16'd0,  4'd0, 1'b1, 1'b0, 16'd0,  4'd0, 3'd0}
        };

        rst = 1'b1;
        a_flush = 0; a_pv = 0; a_pop = 0; a_pd = 0; a_pid = 0;
        b_flush = 0; b_pv = 0; b_pop = 0; b_pd = 0; b_pid = 0;

        // Reset with random traffic applied
        for (int k = 0; k < 2; k++) begin
            a_pv = 1'($urandom); a_pop = 1'($urandom);
            a_pd = 16'($urandom); a_pid = 4'($urandom);
            b_pv = 1'($urandom); b_pop = 1'($urandom);
            b_pd = $urandom; b_pid = 4'($urandom);
            tick();
        end
        chk("rst_empty", a_empty, 1);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_hv", a_hv, 0);
        chk("rst_hd", a_hd, 0);
        chk("rst_hid", a_hid, 0);
        chk("rst_full", a_full, 0);
        chk("rst_b_empty", b_empty, 1);
        chk("rst_b_hd", b_hd, 0);
        rst = 1'b0;
        a_pv = 0; a_pop = 0; b_pv = 0; b_pop = 0;

        // Sorting, stable ties, push+pop on small queues
        for (int i = 0; i < 18; i++) begin
            a_pv = tbl[i].push; a_pd = tbl[i].key;
            a_pid = tbl[i].id; a_pop = tbl[i].pop;
            tick();
            chk($sformatf("vec%0d_hv", i), a_hv, tbl[i].hv);
            chk($sformatf("vec%0d_hd", i), a_hd, tbl[i].hd);
            chk($sformatf("vec%0d_hid", i), a_hid, tbl[i].hid);
            chk($sformatf("vec%0d_cnt", i), a_cnt, tbl[i].cnt);
        end
        a_pv = 0; a_pop = 0;
        chk("vec_end_empty", a_empty, 1);

        // Full boundary
        for (int k = 0; k < 4; k++) begin
            a_pv = 1; a_pd = 16'(k + 2); a_pid = 4'(k + 1);
            tick();
        end
        a_pv = 0;
        chk("full_flag", a_full, 1);
        chk("full_cnt", a_cnt, 4);
        a_pv = 1; a_pd = 16'd6; a_pid = 4'd5;
        #1;
        chk("full_ready", a_pr, 0);
        tick();
        chk("full_hold_cnt", a_cnt, 4);
        chk("full_hold_hd", a_hd, 2);
        a_pd = 16'd1; a_pid = 4'd9; a_pop = 1;
        #1;
        chk("full_pp_ready", a_pr, 1);
        chk("full_pp_popped", a_hd, 2);
        tick();
        a_pv = 0; a_pop = 0;
        chk("full_pp_hd", a_hd, 1);
        chk("full_pp_hid", a_hid, 9);
        chk("full_pp_cnt", a_cnt, 4);
        exp_a = '{16'd3, 16'd4, 16'd5};
        for (int k = 0; k < 3; k++) begin
            a_pop = 1;
            tick();
            chk($sformatf("full_drain%0d", k), a_hd, exp_a[k]);
        end
        tick();
        a_pop = 0;
        chk("full_drain_empty", a_empty, 1);

        // Flush beats a concurrent push; pop on empty
        for (int k = 0; k < 3; k++) begin
            a_pv = 1; a_pd = 16'(11 + k); a_pid = 4'(k);
            tick();
        end
        a_flush = 1; a_pv = 1; a_pd = 16'd8;
        #1;
        chk("flush_ready", a_pr, 0);
        tick();
        a_flush = 0; a_pv = 0;
        chk("flush_cnt", a_cnt, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_hv", a_hv, 0);
        chk("flush_hd", a_hd, 0);
        a_pop = 1;
        tick();
        a_pop = 0;
        chk("empty_pop_cnt", a_cnt, 0);
        chk("empty_pop_hv", a_hv, 0);

        // Max mode, wide keys
        exp_b = '{32'd7, 32'd9, 32'd8, 32'hFFFF_FFFF};
        for (int k = 0; k < 4; k++) begin
            b_pv = 1; b_pd = exp_b[k]; b_pid = 4'(k + 1);
            tick();
        end
        b_pv = 0;
        chk("max_cnt", b_cnt, 4);
        exp_b = '{32'hFFFF_FFFF, 32'd9, 32'd8, 32'd7};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("max_pop%0d", k), b_hd, exp_b[k]);
            b_pop = 1;
            tick();
        end
        b_pop = 0;
        chk("max_empty", b_empty, 1);

        // Random stress against a queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            pv = ($urandom_range(0, 99) < 60);
            pp = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 2);
            nk = ($urandom_range(0, 3) == 0) ? $urandom
                                             : 32'($urandom_range(0, 15));
            nid = 4'($urandom);
            b_pv = pv; b_pop = pp; b_flush = fl; b_pd = nk; b_pid = nid;
            e_pr = !fl && (q.size() < 8 || (pp && q.size() > 0));
            #1;
            chk("st_ready", b_pr, e_pr);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (pp && q.size() > 0) void'(q.pop_front());
                if (pv && e_pr) begin
                    pos = q.size();
                    for (int j = q.size() - 1; j >= 0; j--) begin
                        if ($unsigned(q[j].data) < nk) pos = j;
                    end
                    nc.data = int'(nk);
                    nc.id = int'(nid);
                    q.insert(pos, nc);
                end
            end
            e_hd = (q.size() > 0) ? q[0].data : 32'd0;
            e_hid = (q.size() > 0) ? 4'(q[0].id) : 4'd0;
            chk("st_hv", b_hv, q.size() > 0);
            chk("st_hd", b_hd, e_hd);
            chk("st_hid", b_hid, e_hid);
            chk("st_cnt", b_cnt, q.size());
        end
        b_pv = 0; b_pop = 0; b_flush = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
